// File: rtl/mem_responder.sv
// Word-addressed SRAM responder: a 1024x16 store plus one I/O register at 0x0FFFF,
// driven by active-low CE/OE/WE/UB/LB strobes sampled on the rising edge of Clk.
module mem_responder (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_CE,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic        Mem_UB,
  input  logic        Mem_LB,
  input  logic [19:0] ADDR,
  input  logic [15:0] Data_to_mem,
  input  logic [15:0] Switches,
  output logic [15:0] Data_from_mem,
  output logic [15:0] Hex_out,
  output logic        Busy,
  output logic        Err,
  output logic [1:0]  dbg_state
);

  // Strobe handshake: a request is whatever CE/OE/WE show at a rising edge.
  // CE low with WE low is a write (OE ignored, but OE low too flags an error);
  // CE low with OE low and WE high is a read. Anything else is no request.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    WR1     = 2'd2,
    WR_DONE = 2'd3
  } state_t;

  state_t state;

  logic [15:0] mem [0:1023];

  logic        ce, oe, we;
  logic        rd_req, wr_req;
  logic        in_window, is_io;
  logic [15:0] lane_mask;
  logic [15:0] rd_raw;
  logic [15:0] rd_data;
  logic        commit;

  always_comb begin
    ce        = ~Mem_CE;
    oe        = ~Mem_OE;
    we        = ~Mem_WE;
    rd_req    = ce & oe & ~we;
    wr_req    = ce & we;
    in_window = (ADDR[19:10] == 10'd0);
    is_io     = (ADDR == 20'h0FFFF);
    lane_mask = {{8{~Mem_UB}}, {8{~Mem_LB}}};
    rd_raw    = 16'h0000;
    if (in_window) begin
      rd_raw = mem[ADDR[9:0]];
    end else if (is_io) begin
      rd_raw = Switches;
    end
    rd_data   = rd_raw & lane_mask;
    commit    = ~Reset & (state == WR1) & wr_req;
  end

  // Storage has no reset so its contents survive Reset.
  always_ff @(posedge Clk) begin
    if (commit && in_window) begin
      if (!Mem_UB) mem[ADDR[9:0]][15:8] <= Data_to_mem[15:8];
      if (!Mem_LB) mem[ADDR[9:0]][7:0]  <= Data_to_mem[7:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      Data_from_mem <= 16'h0000;
      Hex_out       <= 16'h0000;
      Err           <= 1'b0;
    end else begin
      if (wr_req && oe) Err <= 1'b1;
      case (state)
        IDLE, RD: begin
          if (wr_req) begin
            state <= WR1;
          end else if (rd_req) begin
            state         <= RD;
            Data_from_mem <= rd_data;
          end else begin
            state <= IDLE;
          end
        end
        WR1: begin
          if (wr_req) begin
            state <= WR_DONE;
            if (is_io) begin
              if (!Mem_UB) Hex_out[15:8] <= Data_to_mem[15:8];
              if (!Mem_LB) Hex_out[7:0]  <= Data_to_mem[7:0];
            end
          end else begin
            // Write strobe withdrawn before the commit edge: aborted cycle.
            Err   <= 1'b1;
            state <= IDLE;
          end
        end
        WR_DONE: begin
          if (!wr_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios with literal expectations, then
// randomized strobe sequences compared every cycle against a behavioural model.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        mem_ce, mem_oe, mem_we, mem_ub, mem_lb;
  logic [19:0] addr;
  logic [15:0] data_to_mem;
  logic [15:0] switches;
  logic [15:0] data_from_mem;
  logic [15:0] hex_out;
  logic        busy;
  logic        err;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  mem_responder dut (
    .Clk          (clk),
    .Reset        (rst),
    .Mem_CE       (mem_ce),
    .Mem_OE       (mem_oe),
    .Mem_WE       (mem_we),
    .Mem_UB       (mem_ub),
    .Mem_LB       (mem_lb),
    .ADDR         (addr),
    .Data_to_mem  (data_to_mem),
    .Switches     (switches),
    .Data_from_mem(data_from_mem),
    .Hex_out      (hex_out),
    .Busy         (busy),
    .Err          (err),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a write commits on the second consecutive edge that
  // shows a write request; a run of exactly one such edge is an abort.
  // A read is served on any read-request edge not directly after a write edge.
  logic [15:0] m_mem [0:1023];
  logic [15:0] m_dfm, m_hex;
  logic        m_err, m_busy;
  int          m_run;

  function automatic logic [15:0] lanes(input logic ub_n, input logic lb_n);
    return {(ub_n ? 8'h00 : 8'hFF), (lb_n ? 8'h00 : 8'hFF)};
  endfunction

  always @(posedge clk) begin
    logic wr, rd;
    logic [15:0] mask, raw;
    if (rst) begin
      m_run = 0; m_dfm = 16'h0; m_hex = 16'h0; m_err = 1'b0; m_busy = 1'b0;
    end else begin
      wr   = !mem_ce && !mem_we;
      rd   = !mem_ce && !mem_oe && mem_we;
      mask = lanes(mem_ub, mem_lb);
      if (wr && !mem_oe) m_err = 1'b1;
      if (wr) begin
        if (m_run < 3) m_run = m_run + 1;
        if (m_run == 2) begin
          if (addr < 20'h00400)
            m_mem[addr[9:0]] = (m_mem[addr[9:0]] & ~mask) | (data_to_mem & mask);
          else if (addr == 20'h0FFFF)
            m_hex = (m_hex & ~mask) | (data_to_mem & mask);
        end
        m_busy = 1'b1;
      end else begin
        if (m_run == 1) m_err = 1'b1;
        if (rd && m_run == 0) begin
          if (addr < 20'h00400) raw = m_mem[addr[9:0]];
          else if (addr == 20'h0FFFF) raw = switches;
          else raw = 16'h0000;
          m_dfm  = raw & mask;
          m_busy = 1'b1;
        end else begin
          m_busy = 1'b0;
        end
        m_run = 0;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every cycle once out of reset
  always @(negedge clk) begin
    if (chk_en) begin
      check("data_from_mem", data_from_mem, m_dfm);
      check("hex_out", hex_out, m_hex);
      check("busy", {15'd0, busy}, {15'd0, m_busy});
      check("err", {15'd0, err}, {15'd0, m_err});
    end
  end

  // Driver tasks: inputs change on the falling edge, one edge per call
  task automatic drive(input logic ce_n, input logic oe_n, input logic we_n,
                       input logic ub_n, input logic lb_n,
                       input logic [19:0] a, input logic [15:0] d);
    mem_ce = ce_n; mem_oe = oe_n; mem_we = we_n; mem_ub = ub_n; mem_lb = lb_n;
    addr = a; data_to_mem = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'h0, 16'h0);
  endtask

  task automatic write_op(input logic [19:0] a, input logic [15:0] d,
                          input logic ub_n, input logic lb_n, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, ub_n, lb_n, a, d);
    idle(1);
  endtask

  task automatic read_op(input logic [19:0] a, input logic ub_n, input logic lb_n, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, ub_n, lb_n, a, 16'h0);
    idle(1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; switches = 16'h0;
    mem_ce = 1'b1; mem_oe = 1'b1; mem_we = 1'b1; mem_ub = 1'b1; mem_lb = 1'b1;
    addr = 20'h0; data_to_mem = 16'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_dfm", data_from_mem, 16'h0000);
    check("reset_hex", hex_out, 16'h0000);
    check("reset_busy", {15'd0, busy}, 16'h0000);
    check("reset_err", {15'd0, err}, 16'h0000);

    // Give every word a known value
    for (int a = 0; a < 1024; a++) write_op(20'(a), 16'($urandom), 1'b0, 1'b0, 2);

    // Basic write then read back, and an upper-lane-masked read
    write_op(20'h00010, 16'h1234, 1'b0, 1'b0, 2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00010, 16'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h00010, 16'h0);
    check("read_second_cycle", data_from_mem, 16'h1234);
    check("read_busy", {15'd0, busy}, 16'h0001);
    idle(1);
    check("read_hold", data_from_mem, 16'h1234);
    check("read_err", {15'd0, err}, 16'h0000);
    read_op(20'h00010, 1'b1, 1'b0, 2);
    check("read_lb_only", data_from_mem, 16'h0034);

    // Lower-lane-only write over zero
    write_op(20'h00020, 16'h0000, 1'b0, 1'b0, 2);
    write_op(20'h00020, 16'hABCD, 1'b1, 1'b0, 2);
    read_op(20'h00020, 1'b0, 1'b0, 2);
    check("lane_write", data_from_mem, 16'h00CD);

    // I/O register, storage alias untouched
    write_op(20'h003FF, 16'h7777, 1'b0, 1'b0, 2);
    switches = 16'h5A5A;
    read_op(20'h0FFFF, 1'b0, 1'b0, 2);
    check("switch_read", data_from_mem, 16'h5A5A);
    write_op(20'h0FFFF, 16'h00FF, 1'b0, 1'b0, 2);
    check("hex_write", hex_out, 16'h00FF);
    read_op(20'h003FF, 1'b0, 1'b0, 2);
    check("hex_no_alias", data_from_mem, 16'h7777);
    read_op(20'h12345, 1'b0, 1'b0, 1);
    check("out_of_window_read", data_from_mem, 16'h0000);

    // Aborted write, then a long write with changing data
    write_op(20'h00030, 16'h1111, 1'b0, 1'b0, 2);
    write_op(20'h00030, 16'hDEAD, 1'b0, 1'b0, 1);
    check("abort_err", {15'd0, err}, 16'h0001);
    read_op(20'h00030, 1'b0, 1'b0, 2);
    check("abort_no_write", data_from_mem, 16'h1111);
    do_reset(1);
    check("err_cleared", {15'd0, err}, 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00030, 16'hA001);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00030, 16'hA002);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00030, 16'hA003);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00030, 16'hA004);
    idle(1);
    read_op(20'h00030, 1'b0, 1'b0, 2);
    check("long_write", data_from_mem, 16'hA002);
    check("long_write_err", {15'd0, err}, 16'h0000);

    // Reset while in WR1
    write_op(20'h00040, 16'h2222, 1'b0, 1'b0, 2);
    write_op(20'h0FFFF, 16'h0F0F, 1'b0, 1'b0, 2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00040, 16'h9999);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00040, 16'h9999);
    rst = 1'b0;
    idle(1);
    check("rst_wr1_hex", hex_out, 16'h0000);
    check("rst_wr1_err", {15'd0, err}, 16'h0000);
    check("rst_wr1_busy", {15'd0, busy}, 16'h0000);
    read_op(20'h00040, 1'b0, 1'b0, 2);
    check("rst_wr1_no_commit", data_from_mem, 16'h2222);
    read_op(20'h00010, 1'b0, 1'b0, 2);
    check("storage_survives_reset", data_from_mem, 16'h1234);

    // Randomized strobe sequences
    for (int op = 0; op < 800; op++) begin
      int kind, len;
      logic [19:0] a;
      logic [15:0] d;
      logic ub_n, lb_n;
      kind = $urandom_range(0, 11);
      len  = $urandom_range(1, 4);
      case ($urandom_range(0, 7))
        0:       a = 20'h0FFFF;
        1:       a = 20'h00400 + 20'($urandom_range(0, 20'hFEBFF));
        default: a = 20'($urandom_range(0, 1023));
      endcase
      ub_n = ($urandom_range(0, 3) == 0);
      lb_n = ($urandom_range(0, 3) == 0);
      d = 16'($urandom);
      switches = 16'($urandom);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 2) == 0) d = 16'($urandom);
        if ($urandom_range(0, 5) == 0) a = 20'($urandom_range(0, 1023));
        rst = ($urandom_range(0, 149) == 0);
        if (kind < 4)       drive(1'b0, 1'b0, 1'b1, ub_n, lb_n, a, d);
        else if (kind < 8)  drive(1'b0, 1'b1, 1'b0, ub_n, lb_n, a, d);
        else if (kind == 8) drive(1'b0, 1'b0, 1'b0, ub_n, lb_n, a, d);
        else if (kind == 9) drive(1'b1, 1'($urandom), 1'($urandom), ub_n, lb_n, a, d);
        else                drive(1'b0, 1'b1, 1'b1, ub_n, lb_n, a, d);
      end
      rst = 1'b0;
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
